multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multi-cycle control unit for the 16-bit CPU datapath (instr [15:12]=op, [11:8]=rs, [7:4]=rt, [3:0]=rd/imm4).
//   Sequences fetch/decode/execute/memory/writeback over several clocks, sharing one ALU and one memory port.
//   Stalls on a memory ready handshake and keeps a retired-instruction counter for debug.
// PARAMETERS
//   OP_W   4   opcode width
//   CNT_W  16  retired-instruction counter width
// PORTS
//   CLK        in   1      system clock, all state updates on rising edge
//   RESET      in   1      synchronous, active-high reset
//   op         in   OP_W   opcode from instruction register (stable after FETCH)
//   zero       in   1      ALU zero flag (valid in EXEC)
//   mem_ready  in   1      memory completes current read/write this cycle
//   PCWrite    out  1      load PC this cycle
//   PCSrc      out  2      0=PC+1, 1=branch target, 2=jump target
//   IRWrite    out  1      load instruction register
//   MemRead    out  1      memory read request (instruction or data)
//   MemWrite   out  1      memory write request
//   IorD       out  1      0=address from PC, 1=address from ALU result
//   RegWrite   out  1      register file write enable
//   MemtoReg   out  1      1=writeback from memory data, 0=from ALU
//   ALUSrcB    out  1      0=ReadData2, 1=zero-extended imm4
//   ALUOp      out  3      0=ADD 1=SUB 2=AND 3=OR
//   state      out  3      current FSM state (debug)
//   halted     out  1      1 while in HALT
//   retired    out  CNT_W  count of completed instructions
// BEHAVIOUR
//   Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 JMP, F HALT; 9-E = NOP.
//   States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6-7 -> FETCH next cycle.
//   Reset: state=FETCH, retired=0, halted=0. All strobes=0 while RESET=1. RESET mid-instruction aborts it, with no partial write.
//   Strobes are combinational from (state, op, zero, mem_ready). Unlisted outputs are 0 in each state.
//   FETCH: MemRead=1, IorD=0. Hold until mem_ready.
//     When mem_ready: IRWrite=1, PCWrite=1, PCSrc=0, next=DECODE.
//   DECODE: op=F -> HALT.
//     op=8 -> PCWrite=1, PCSrc=2, retired++, next=FETCH.
//     NOP -> retired++, next=FETCH.
//     Otherwise next=EXEC.
//   EXEC: ADD/SUB/AND/OR -> ALUOp per op, ALUSrcB=0, next=WB.
//     ADDI -> ALUOp=0, ALUSrcB=1, next=WB.
//     LW/SW -> ALUOp=0, ALUSrcB=1 (address=rs+imm4), next=MEM.
//     BEQ -> ALUOp=1, ALUSrcB=0, PCWrite=zero, PCSrc=1, retired++, next=FETCH.
//   MEM: IorD=1. LW -> MemRead=1; SW -> MemWrite=1. Request held until mem_ready.
//     On mem_ready: LW next=WB; SW retired++, next=FETCH.
//   WB: RegWrite=1, MemtoReg=(op==5), retired++, next=FETCH.
//   HALT: all strobes 0, halted=1. Only RESET leaves it.
//   Latency with mem_ready tied 1 (cycles per instr): JMP/NOP 2, BEQ 3, R-type/ADDI/SW 4, LW 5.
//     Each cycle mem_ready is low adds exactly 1.
//   MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
//   retired wraps modulo 2^CNT_W and increments at most once per instruction.
//   mem_ready is ignored outside FETCH/MEM. op is ignored in FETCH.
// TESTING
//   mem_ready=1, op=0 (ADD): states 0,1,2,4,0; RegWrite only in WB; retired 0->1 after 4 cycles.
//   op=5 (LW), mem_ready low 3 cycles in MEM: MemRead+IorD held 3 cycles, then WB with MemtoReg=1; total 8 cycles.
//   op=7 (BEQ): zero=1 -> PCWrite=1, PCSrc=1 in EXEC; zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
//   op=6 (SW) then op=8 (JMP): MemWrite 1 cycle with IorD=1, no RegWrite; JMP gives PCSrc=2 in DECODE; retired=2.
//   op=F: HALT reached, halted=1, all strobes 0 for 20 cycles; RESET=1 one cycle -> state=0, retired=0.
//   RESET asserted in MEM during SW with mem_ready=0: no MemWrite after the reset edge; state=FETCH next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the 16-bit CPU: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and memory port, stalling on mem_ready and counting retired instructions.
//
//   state  | meaning
//   FETCH  | read instruction at PC, load IR and PC+1 when memory is ready
//   DECODE | classify opcode; JMP and NOP complete here, HALT parks
//   EXEC   | drive ALU (R-type, ADDI, address calc, BEQ compare + branch)
//   MEM    | data read (LW) or write (SW) at ALU address, held until ready
//   WB     | write ALU result or load data to register file
//   HALT   | parked with all strobes low until RESET
module multicycle_ctrl #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [OP_W-1:0]  op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic [2:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_JMP  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

   state_t curState;
   state_t nextState;
   logic   retireNow;

   always_comb begin
      PCWrite   = 1'b0;
      PCSrc     = 2'd0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      RegWrite  = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'd0;
      retireNow = 1'b0;
      nextState = curState;

      case (curState)
         FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               nextState = DECODE;
            end
         end

         DECODE: begin
            case (op)
               OP_HALT: nextState = HALT;
               OP_JMP: begin
                  PCWrite   = 1'b1;
                  PCSrc     = 2'd2;
                  retireNow = 1'b1;
                  nextState = FETCH;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_ADDI, OP_LW, OP_SW, OP_BEQ: nextState = EXEC;
               default: begin
                  retireNow = 1'b1;
                  nextState = FETCH;
               end
            endcase
         end

         EXEC: begin
            case (op)
               OP_ADD: nextState = WB;
               OP_SUB: begin
                  ALUOp     = 3'd1;
                  nextState = WB;
               end
               OP_AND: begin
                  ALUOp     = 3'd2;
                  nextState = WB;
               end
               OP_OR: begin
                  ALUOp     = 3'd3;
                  nextState = WB;
               end
               OP_ADDI: begin
                  ALUSrcB   = 1'b1;
                  nextState = WB;
               end
               OP_LW, OP_SW: begin
                  ALUSrcB   = 1'b1;
                  nextState = MEM;
               end
               OP_BEQ: begin
                  ALUOp     = 3'd1;
                  PCWrite   = zero;
                  PCSrc     = 2'd1;
                  retireNow = 1'b1;
                  nextState = FETCH;
               end
               default: nextState = FETCH;
            endcase
         end

         MEM: begin
            IorD     = 1'b1;
            MemRead  = (op == OP_LW);
            MemWrite = (op == OP_SW);
            if (mem_ready) begin
               if (op == OP_LW) begin
                  nextState = WB;
               end else begin
                  retireNow = (op == OP_SW);
                  nextState = FETCH;
               end
            end
         end

         WB: begin
            RegWrite  = 1'b1;
            MemtoReg  = (op == OP_LW);
            retireNow = 1'b1;
            nextState = FETCH;
         end

         HALT: nextState = HALT;

         default: nextState = FETCH;
      endcase

      // Reset aborts the instruction in flight: no request or write may leak out this cycle.
      if (RESET) begin
         PCWrite  = 1'b0;
         PCSrc    = 2'd0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IorD     = 1'b0;
         RegWrite = 1'b0;
         MemtoReg = 1'b0;
         ALUSrcB  = 1'b0;
         ALUOp    = 3'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         curState <= FETCH;
         retired  <= '0;
      end else begin
         curState <= nextState;
         if (retireNow) begin
            retired <= retired + 1'b1;
         end
      end
   end

   assign state  = curState;
   assign halted = (curState == HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expands each instruction class into its expected per-cycle
// output sequence and compares every cycle, plus literal latency and retire-count checks.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [2:0]  st;
      logic        pcw;
      logic [1:0]  pcs;
      logic        irw;
      logic        mr;
      logic        mw;
      logic        iord;
      logic        rw;
      logic        m2r;
      logic        asb;
      logic [2:0]  aluop;
      logic        hlt;
      logic [15:0] ret;
   } outs_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [3:0]  op = 4'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        PCWrite;
   logic [1:0]  PCSrc;
   logic        IRWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        IorD;
   logic        RegWrite;
   logic        MemtoReg;
   logic        ALUSrcB;
   logic [2:0]  ALUOp;
   logic [2:0]  state;
   logic        halted;
   logic [15:0] retired;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] retModel = '0;
   int          lat;

   multicycle_ctrl #(.OP_W(4), .CNT_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .op(op), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state), .halted(halted), .retired(retired)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic outs_t blank(input logic [2:0] st);
      outs_t e;
      e     = '0;
      e.st  = st;
      e.hlt = (st == 3'd5);
      e.ret = retModel;
      return e;
   endfunction

   // One clock cycle: drive inputs on the falling edge, compare once they settle.
   task automatic step(input outs_t e, input logic [3:0] opIn, input logic mr,
                       input logic z, input logic rst, input string tag);
      outs_t act;
      @(negedge CLK);
      op        = opIn;
      mem_ready = mr;
      zero      = z;
      RESET     = rst;
      #1;
      act = {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD, RegWrite,
             MemtoReg, ALUSrcB, ALUOp, halted, retired};
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s op=%h: got %h want %h", tag, opIn, act, e);
      end
   endtask

   task automatic checkLit(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic doInstr(input logic [3:0] opc, input logic z, input int fetchStall,
                          input int memStall, input bit abortInMem, output int cycles);
      outs_t e;
      cycles = 0;
      for (int i = 0; i < fetchStall; i++) begin
         e = blank(3'd0); e.mr = 1'b1;
         step(e, 4'($urandom), 1'b0, rb(), 1'b0, "fetch_wait"); cycles++;
      end
      e = blank(3'd0); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
      step(e, 4'($urandom), 1'b1, rb(), 1'b0, "fetch"); cycles++;

      e = blank(3'd1);
      if (opc == 4'hF) begin
         step(e, opc, rb(), rb(), 1'b0, "decode_halt"); cycles++;
         for (int i = 0; i < 20; i++) begin
            step(blank(3'd5), opc, rb(), rb(), 1'b0, "halt"); cycles++;
         end
         return;
      end
      if (opc == 4'h8) begin
         e.pcw = 1'b1; e.pcs = 2'd2;
         step(e, opc, rb(), rb(), 1'b0, "decode_jmp"); cycles++;
         retModel++;
         return;
      end
      if (opc > 4'h8) begin
         step(e, opc, rb(), rb(), 1'b0, "decode_nop"); cycles++;
         retModel++;
         return;
      end
      step(e, opc, rb(), rb(), 1'b0, "decode"); cycles++;

      e = blank(3'd2);
      if (opc == 4'h7) begin
         e.aluop = 3'd1; e.pcw = z; e.pcs = 2'd1;
         step(e, opc, rb(), z, 1'b0, "exec_beq"); cycles++;
         retModel++;
         return;
      end
      if (opc <= 4'h3) e.aluop = 3'(opc);
      else             e.asb   = 1'b1;
      step(e, opc, rb(), rb(), 1'b0, "exec"); cycles++;

      if (opc == 4'h5 || opc == 4'h6) begin
         e = blank(3'd3); e.iord = 1'b1; e.mr = (opc == 4'h5); e.mw = (opc == 4'h6);
         for (int i = 0; i < memStall; i++) begin
            step(e, opc, 1'b0, rb(), 1'b0, "mem_wait"); cycles++;
         end
         if (abortInMem) begin
            step(blank(3'd3), opc, 1'b0, rb(), 1'b1, "mem_reset"); cycles++;
            retModel = '0;
            return;
         end
         step(e, opc, 1'b1, rb(), 1'b0, "mem"); cycles++;
         if (opc == 4'h6) begin
            retModel++;
            return;
         end
      end

      e = blank(3'd4); e.rw = 1'b1; e.m2r = (opc == 4'h5);
      step(e, opc, rb(), rb(), 1'b0, "wb"); cycles++;
      retModel++;
   endtask

   initial begin
      RESET = 1'b1;
      step(blank(3'd0), 4'h0, 1'b1, 1'b0, 1'b1, "reset");

      doInstr(4'h0, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_add", lat, 4);
      checkLit("ret_add", int'(retModel), 1);
      doInstr(4'h5, 1'b0, 0, 3, 1'b0, lat); checkLit("lat_lw_stall3", lat, 8);
      doInstr(4'h7, 1'b1, 0, 0, 1'b0, lat); checkLit("lat_beq_taken", lat, 3);
      doInstr(4'h7, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_beq_not", lat, 3);
      doInstr(4'h6, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_sw", lat, 4);
      doInstr(4'h8, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_jmp", lat, 2);
      checkLit("ret_six", int'(retModel), 6);

      doInstr(4'h1, 1'b0, 2, 0, 1'b0, lat); checkLit("lat_sub_fstall2", lat, 6);
      doInstr(4'h2, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_and", lat, 4);
      doInstr(4'h3, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_or", lat, 4);
      doInstr(4'h4, 1'b0, 1, 0, 1'b0, lat); checkLit("lat_addi_fstall1", lat, 5);
      doInstr(4'h5, 1'b0, 1, 1, 1'b0, lat); checkLit("lat_lw_both", lat, 7);
      doInstr(4'h6, 1'b0, 0, 2, 1'b0, lat); checkLit("lat_sw_mstall2", lat, 6);
      doInstr(4'h9, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_nop9", lat, 2);
      doInstr(4'hE, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_nopE", lat, 2);
      checkLit("ret_fourteen", int'(retModel), 14);

      doInstr(4'h6, 1'b0, 0, 1, 1'b1, lat); checkLit("ret_after_abort", int'(retModel), 0);
      doInstr(4'h0, 1'b0, 1, 0, 1'b0, lat); checkLit("lat_add_after_abort", lat, 5);

      doInstr(4'hF, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_halt_window", lat, 22);
      step(blank(3'd5), 4'hF, 1'b1, 1'b0, 1'b1, "halt_reset");
      retModel = '0;
      doInstr(4'h0, 1'b0, 0, 0, 1'b0, lat); checkLit("lat_add_after_halt", lat, 4);
      checkLit("ret_after_halt", int'(retModel), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
